// File: rtl/cond_flag_unit.sv
// NZCV flag register plus B.cond / CBZ / CBNZ branch resolver with taken-branch counter.
// Latency: decision registered one cycle after the request; flag write visible next cycle.
// No backpressure: accepts one request every cycle, results strobe out with take_valid.
module cond_flag_unit #(
    parameter bit FWD   = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flag_we,
    input  logic             negative_in,
    input  logic             zero_in,
    input  logic             overflow_in,
    input  logic             carry_in,
    input  logic             cond_valid,
    input  logic [3:0]       cond,
    input  logic             cbz_valid,
    input  logic             cbz_nz,
    output logic [3:0]       flags,
    output logic             flags_valid,
    output logic             take,
    output logic             take_valid,
    output logic             conflict,
    output logic [CNT_W-1:0] taken_cnt
);

    logic [3:0] in_flags;
    logic [3:0] efl;
    logic       fwd_hit;
    logic       efl_ok;
    logic       cond_res;
    logic       take_next;
    logic       req;
    logic       armed;

    assign in_flags = {negative_in, zero_in, carry_in, overflow_in};
    assign fwd_hit  = FWD && flag_we;
    assign efl      = fwd_hit ? in_flags : flags;
    assign efl_ok   = flags_valid || fwd_hit;

    // Requests arriving in the cycle reset drops are ignored: armed only rises on the first edge.
    assign req = (cond_valid || cbz_valid) && armed;

    // Condition-code lookup on the effective {N,Z,C,V}
    always_comb begin
        cond_res = 1'b0;
        case (cond)
            4'h0: cond_res = efl[2];
            4'h1: cond_res = !efl[2];
            4'h2: cond_res = efl[1];
            4'h3: cond_res = !efl[1];
            4'h4: cond_res = efl[3];
            4'h5: cond_res = !efl[3];
            4'h6: cond_res = efl[0];
            4'h7: cond_res = !efl[0];
            4'h8: cond_res = efl[1] && !efl[2];
            4'h9: cond_res = !(efl[1] && !efl[2]);
            4'hA: cond_res = (efl[3] == efl[0]);
            4'hB: cond_res = (efl[3] != efl[0]);
            4'hC: cond_res = !efl[2] && (efl[3] == efl[0]);
            4'hD: cond_res = !(!efl[2] && (efl[3] == efl[0]));
            default: cond_res = 1'b1;
        endcase
    end

    // Pick the branch outcome; B.cond wins over CBZ/CBNZ, and without any flags only AL/NV take
    always_comb begin
        take_next = 1'b0;
        if (cond_valid) begin
            if (cond[3:1] == 3'b111) begin
                take_next = 1'b1;
            end else begin
                take_next = efl_ok && cond_res;
            end
        end else begin
            take_next = cbz_nz ? !zero_in : zero_in;
        end
    end

    // Arm the decision path one edge after reset release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // NZCV register: only flag-setting ALU ops write it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags       <= 4'b0000;
            flags_valid <= 1'b0;
        end else if (flag_we) begin
            flags       <= in_flags;
            flags_valid <= 1'b1;
        end
    end

    // Registered decision, strobes and taken counter (wraps silently)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            take       <= 1'b0;
            take_valid <= 1'b0;
            conflict   <= 1'b0;
            taken_cnt  <= '0;
        end else begin
            take_valid <= req;
            conflict   <= req && cond_valid && cbz_valid;
            if (req) begin
                take <= take_next;
            end
            if (req && take_next) begin
                taken_cnt <= taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench: two instances (forwarding on / off) share one stimulus stream.
// Stimulus pushes expected decisions from a reference model; a negedge monitor pops and compares.
// Reset is exercised at start and mid-stream.
module tb_cond_flag_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flag_we = 1'b0, negative_in = 1'b0, zero_in = 1'b0, overflow_in = 1'b0, carry_in = 1'b0;
    logic cond_valid = 1'b0, cbz_valid = 1'b0, cbz_nz = 1'b0;
    logic [3:0] cond = 4'h0;

    logic [3:0] fl_a, fl_b;
    logic       fv_a, fv_b, tk_a, tk_b, tv_a, tv_b, cf_a, cf_b;
    logic [3:0] cnt_a, cnt_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int       at;
        bit       take;
        bit       conflict;
        bit [3:0] flags;
        bit       fv;
        int       cnt;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    // reference model state; index 0 = forwarding instance, 1 = non-forwarding
    bit [3:0] m_fl [2];
    bit       m_fv [2];
    int       m_cnt[2];
    bit       m_armed;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cond_flag_unit #(.FWD(1'b1), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .flag_we(flag_we), .negative_in(negative_in),
        .zero_in(zero_in), .overflow_in(overflow_in), .carry_in(carry_in),
        .cond_valid(cond_valid), .cond(cond), .cbz_valid(cbz_valid), .cbz_nz(cbz_nz),
        .flags(fl_a), .flags_valid(fv_a), .take(tk_a), .take_valid(tv_a),
        .conflict(cf_a), .taken_cnt(cnt_a)
    );

    cond_flag_unit #(.FWD(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .flag_we(flag_we), .negative_in(negative_in),
        .zero_in(zero_in), .overflow_in(overflow_in), .carry_in(carry_in),
        .cond_valid(cond_valid), .cond(cond), .cbz_valid(cbz_valid), .cbz_nz(cbz_nz),
        .flags(fl_b), .flags_valid(fv_b), .take(tk_b), .take_valid(tv_b),
        .conflict(cf_b), .taken_cnt(cnt_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ARM condition semantics, straight from the architectural definitions
    function automatic bit cond_true(input int c, input bit n, input bit z, input bit cc, input bit v);
        bit ge, gt, hi;
        ge = (n == v);
        gt = !z && ge;
        hi = cc && !z;
        case (c)
            0: return z;      1: return !z;
            2: return cc;     3: return !cc;
            4: return n;      5: return !n;
            6: return v;      7: return !v;
            8: return hi;     9: return !hi;
            10: return ge;    11: return !ge;
            12: return gt;    13: return !gt;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_fl[i] = 4'b0000; m_fv[i] = 1'b0; m_cnt[i] = 0;
        end
        m_armed = 1'b0;
        sb_a.delete();
        sb_b.delete();
    endtask

    // Drive one cycle of inputs, predict its outcome, then advance past the edge
    task automatic step(input bit we, input bit n, input bit z, input bit c, input bit v,
                        input bit cv, input int cd, input bit bz, input bit nz);
        bit [3:0] inf;
        flag_we = we; negative_in = n; zero_in = z; carry_in = c; overflow_in = v;
        cond_valid = cv; cond = 4'(cd); cbz_valid = bz; cbz_nz = nz;
        inf = {n, z, c, v};
        for (int i = 0; i < 2; i++) begin
            bit fwd;
            bit [3:0] e;
            bit ok;
            bit t;
            exp_t x;
            fwd = (i == 0) && we;
            e   = fwd ? inf : m_fl[i];
            ok  = m_fv[i] || fwd;
            if (cv) begin
                if (cd >= 14) t = 1'b1;
                else if (!ok) t = 1'b0;
                else t = cond_true(cd, e[3], e[2], e[1], e[0]);
            end else begin
                t = nz ? !z : z;
            end
            if (we) begin
                m_fl[i] = inf;
                m_fv[i] = 1'b1;
            end
            if (m_armed && (cv || bz)) begin
                if (t) m_cnt[i] = (m_cnt[i] + 1) % 16;
                x.at = cyc + 1; x.take = t; x.conflict = cv && bz;
                x.flags = m_fl[i]; x.fv = m_fv[i]; x.cnt = m_cnt[i];
                if (i == 0) sb_a.push_back(x);
                else sb_b.push_back(x);
            end
        end
        m_armed = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " flags_a"}, fl_a, 0);  chk({tag, " flags_b"}, fl_b, 0);
        chk({tag, " fv_a"}, fv_a, 0);     chk({tag, " fv_b"}, fv_b, 0);
        chk({tag, " take_a"}, tk_a, 0);   chk({tag, " take_b"}, tk_b, 0);
        chk({tag, " tv_a"}, tv_a, 0);     chk({tag, " tv_b"}, tv_b, 0);
        chk({tag, " conf_a"}, cf_a, 0);   chk({tag, " conf_b"}, cf_b, 0);
        chk({tag, " cnt_a"}, cnt_a, 0);   chk({tag, " cnt_b"}, cnt_b, 0);
    endtask

    task automatic mon(input int i, input bit tv, input bit tk, input bit cf,
                       input bit [3:0] fl, input bit fv, input int cnt);
        exp_t x;
        string s;
        s = (i == 0) ? "a" : "b";
        if (!tv) begin
            chk({"idle_conflict_", s}, cf, 0);
        end else if ((i == 0 && sb_a.size() == 0) || (i == 1 && sb_b.size() == 0)) begin
            chk({"unexpected_take_valid_", s}, 1, 0);
        end else begin
            x = (i == 0) ? sb_a.pop_front() : sb_b.pop_front();
            chk({"cycle_", s}, cyc, x.at);
            chk({"take_", s}, tk, x.take);
            chk({"conflict_", s}, cf, x.conflict);
            chk({"flags_", s}, fl, x.flags);
            chk({"flags_valid_", s}, fv, x.fv);
            chk({"taken_cnt_", s}, cnt, x.cnt);
        end
    endtask

    // Monitor: compare whenever a decision strobe appears
    always @(negedge clk) begin
        if (!reset) begin
            mon(0, tv_a, tk_a, cf_a, fl_a, fv_a, cnt_a);
            mon(1, tv_b, tk_b, cf_b, fl_b, fv_b, cnt_b);
        end
    end

    initial begin
        model_reset();
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        idle();

        // no flags yet: EQ not taken, AL taken
        step(0, 0, 0, 0, 0, 1, 4'h0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 4'h1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 4'hE, 0, 0);
        idle();

        // N=1: LT taken, GE and GT not
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 4'hB, 0, 0);
        step(0, 0, 0, 0, 0, 1, 4'hA, 0, 0);
        step(0, 0, 0, 0, 0, 1, 4'hC, 0, 0);

        // clear flags, then same-cycle Z write with EQ: forwarded vs stored
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 1, 4'h0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 4'h0, 0, 0);

        // CBZ / CBNZ, flags must be untouched
        step(0, 0, 1, 0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);

        // both requests: NE with Z stored wins over a taken CBZ
        step(0, 0, 1, 0, 0, 1, 4'h1, 1, 0);
        idle();

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 9) < 4, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                 $urandom_range(0, 9) < 3, 1'($urandom));
        end
        idle();

        // counter wrap: reset mid-cycle, then 17 AL requests end with count 1
        reset = 1'b1;
        #1;
        chk_all_zero("midreset1");
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        idle();
        for (int k = 0; k < 17; k++) step(0, 0, 0, 0, 0, 1, 4'hE, 0, 0);
        chk("wrap_cnt_model", m_cnt[0], 1);

        // reset while requests keep flowing; the release cycle's request must not decide
        step(0, 0, 0, 0, 0, 1, 4'hF, 0, 0);
        reset = 1'b1;
        #1;
        chk_all_zero("midreset2");
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        step(1, 0, 1, 0, 0, 1, 4'hE, 0, 0);
        #1;
        chk("post_reset_tv_a", tv_a, 0);
        chk("post_reset_tv_b", tv_b, 0);
        step(0, 0, 0, 0, 0, 1, 4'hE, 0, 0);
        step(0, 0, 0, 0, 0, 1, 4'h0, 0, 0);
        repeat (3) idle();

        chk("leftover_a", sb_a.size(), 0);
        chk("leftover_b", sb_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Consumer of the 64-bit ALU's status outputs (negative, zero, overflow, carry_out) in the LEGv8 datapath.
- Latches NZCV on flag-setting instructions (ADDS/SUBS/ANDS).
- Evaluates B.cond condition codes against the stored or forwarded flags, and CBZ/CBNZ against the ALU zero output.
- Issues a registered branch decision with a valid strobe, and keeps a taken-branch counter for performance checks.

Parameters:
- FWD, 1, 1 = a B.cond in the same cycle as a flag write uses the incoming flags; 0 = uses the stored flags.
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flag_we  input  1  write the NZCV register this cycle
- negative_in  input  1  ALU negative
- zero_in  input  1  ALU zero; also the CBZ/CBNZ test operand
- overflow_in  input  1  ALU overflow
- carry_in  input  1  ALU carry_out
- cond_valid  input  1  B.cond request
- cond  input  4  ARM condition code
- cbz_valid  input  1  CBZ/CBNZ request
- cbz_nz  input  1  0 = CBZ, 1 = CBNZ
- flags  output  4  stored {N,Z,C,V}
- flags_valid  output  1  set once any flag write has occurred since reset
- take  output  1  registered branch decision
- take_valid  output  1  one-cycle strobe qualifying take
- conflict  output  1  one-cycle strobe: cond_valid and cbz_valid were both high
- taken_cnt  output  CNT_W  count of taken decisions

Behaviour:
- Reset (asynchronous, effective immediately, including mid-operation):
  - flags=0, flags_valid=0, take=0, take_valid=0, conflict=0, taken_cnt=0.
  - A request in the cycle reset deasserts produces no decision.
- Flag register:
  - On a clk edge with flag_we=1: flags <= {negative_in, zero_in, carry_in, overflow_in}; flags_valid <= 1.
  - flag_we=0: flags hold.
- Effective flags (efl) for evaluation:
  - If FWD=1 and flag_we=1 in the same cycle, efl = the incoming flags.
  - Otherwise efl = the stored flags.
- Condition table on efl:
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !(C&!Z)
  - A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE !(GT)
  - E AL 1; F NV 1 (always, per ARMv8)
- Decision, with 1-cycle latency: on the edge after a request, take_valid=1 for exactly one cycle and take holds the result.
  - take holds its value until the next decision; take_valid=0 otherwise.
- cond_valid only: take = table(cond, efl).
  - If flags_valid=0 and there is no same-cycle forwarded write, take=0 for every cond except E/F.
- cbz_valid only: take = cbz_nz ? !zero_in : zero_in. CBZ/CBNZ never read or modify the flag register.
- Both requests high: cond_valid has priority; conflict=1 for one cycle alongside take_valid.
- Back-to-back requests on consecutive cycles produce consecutive take_valid pulses; no bubbles, no stall.
- taken_cnt increments by 1 on every edge where the new take_valid=1 and take=1.
  - Wraps from 2^CNT_W-1 to 0 without a flag.
- flag_we alone never produces take_valid.

Test Plan:
1. Reset, then cond_valid with cond=0 (EQ), no prior flag write -> next cycle take_valid=1, take=0, flags_valid=0; cond=E -> take=1.
2. flag_we with N=1,Z=0,C=0,V=0, then cond=B (LT) -> take=1 and flags=4'b1000; cond=A (GE) -> take=0; cond=C (GT) -> take=0.
3. FWD=1: stored flags 0000; same cycle flag_we Z=1 and cond=0 (EQ) -> take=1. Repeat with FWD=0 -> take=0, and flags becomes 0100 afterwards.
4. cbz_valid with cbz_nz=0, zero_in=1 -> take=1; cbz_nz=1, zero_in=1 -> take=0; flags unchanged throughout.
5. cond_valid (cond=1, Z stored=1) and cbz_valid (zero_in=1) together -> take=0 (cond result), conflict=1 for one cycle; taken_cnt unchanged.
6. CNT_W=4: 17 consecutive AL requests -> 17 take_valid pulses, taken_cnt sequence ends at 1 (wrapped). Then assert reset mid-stream -> all outputs 0 immediately, and no take_valid on the first post-reset edge.
